mem_requester: RTL
==================

Name: mem_requester

Overview:
- Initiator side of the data-memory handshake. Sits between the core's load/store stage and the large BRAM-backed memory.
- Accepts one load/store request at a time and drives the memory's write and read channels.
- Sub-word stores are performed as read-modify-write; load data is lane-aligned and sign/zero-extended.
- Returns a single-cycle response carrying read data or an error flag.

Parameters:
- MEM_WORDS, 655360, number of 32-bit words backing the memory; word index >= MEM_WORDS is out of range.
- TIMEOUT_CYCLES, 64, maximum cycles a memory valid may stay high without ready before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word (3 is illegal)
- req_signed  in  1  sign-extend a load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, illegal size, out of range, or timeout
- bus_fault  out  1  sticky: any resp_error or mem_addr_error since reset
- mem_in_addr  out  32  write address, word-aligned
- mem_in_data  out  32  write data
- mem_in_valid  out  1  write request
- mem_in_ready  in  1  write done
- mem_out_addr  out  32  read address, word-aligned
- mem_out_valid  out  1  read request
- mem_out_data  in  32  read data, valid while mem_out_ready
- mem_out_ready  in  1  read done
- mem_addr_error  in  1  memory's sticky range error

Behaviour:
- Reset values:
  - all outputs 0 except req_ready=1;
  - state IDLE, timeout counter 0, bus_fault 0.
  - Reset mid-operation abandons the access with no response.
- FSM states: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- req_ready = (state==IDLE). A request is accepted on the edge where req_valid && req_ready.
- Error check at acceptance (combinational on request fields):
  - size==3;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
  - On error: go to RESP with resp_error=1 and no memory access.
- Otherwise:
  - load -> READ;
  - word store -> WRITE;
  - byte/half store -> RMW_READ.
  - The word address (addr with [1:0]=0), lane (addr[1:0]), size, signed flag and wdata are registered.
- mem_in_valid is registered high for the whole of WRITE/RMW_WRITE. mem_out_valid is registered high for the whole of READ/RMW_READ. The two are never high together.
- Ready sampling: the edge that samples ready=1 leaves the state and clears valid in the same edge, so valid is never high in the cycle after ready. This prevents a duplicate write.
- READ: on mem_out_ready, capture the lane-extracted, extended data, then go to RESP.
- RMW_READ: on mem_out_ready, merge wdata into the read word (little-endian lane), then go to RMW_WRITE. Valid goes low for exactly one cycle between the read and write phases.
- WRITE / RMW_WRITE: on mem_in_ready, go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata and resp_error hold until the next response.
- Nominal latency, counted from the acceptance edge (cycle 0):
  - error response in cycle 1;
  - word store ready in cycle 2, response cycle 3;
  - load ready in cycle 3, response cycle 4;
  - sub-word store response cycle 7.
- Timeout:
  - The counter resets on each state entry and increments while a valid is high.
  - Reaching TIMEOUT_CYCLES drops valid, goes to RESP with resp_error=1, and sets bus_fault.
- Load extension:
  - byte: bits[8*lane+7:8*lane];
  - half: bits[16*lane[1]+15:16*lane[1]];
  - upper bits = sign bit if req_signed, else 0.
- bus_fault is set by any resp_error or mem_addr_error and is cleared only by reset.

Decomposition:
- Package mem_req_pkg holds:
  - the size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
  - the state enum;
  - default MEM_WORDS and TIMEOUT_CYCLES.
- Sub-module mem_lane_align (combinational): extract+extend for loads, merge for stores.

Test Plan:
- Word store 0xDEADBEEF to 0x100, then word load 0x100 -> mem_in_valid high for 2 cycles; resp cycle 3 with resp_error=0; load resp cycle 4 with rdata=0xDEADBEEF.
- Byte store 0x80 to 0x101 over 0xDEADBEEF, then signed byte load 0x101, then unsigned half load 0x100 -> memory word 0xDEAD80EF; rdata=0xFFFFFF80; rdata=0x000080EF.
- Word load at 0x102, and half store at 0x103 -> each responds cycle 1 with resp_error=1 and zero memory valids; bus_fault=1.
- Load at word index 655360 (addr 0x00280000) -> immediate resp_error=1, no mem_out_valid.
- Memory model holds ready low -> after 64 cycles valid drops, resp_error=1, bus_fault=1; the next request succeeds normally.
- Reset asserted in RMW_READ cycle 2 -> next cycle all valids=0, req_ready=1, no resp_valid; the following word store completes in 3 cycles.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and defaults for the data-memory requester.
package mem_req_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_READ,
        RMW_WRITE,
        RESP
    } state_e;

    localparam int unsigned DEFAULT_MEM_WORDS      = 655360;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
import mem_req_pkg::*;

module mem_lane_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = rdata[{lane, 3'b000} +: 8];
        half_v    = rdata[{lane[1], 4'b0000} +: 16];
        load_data = rdata;
        merged    = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{sgn & byte_v[7]}}, byte_v};
                merged    = rdata;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{sgn & half_v[15]}}, half_v};
                merged    = rdata;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_requester.sv
// Load/store initiator for the BRAM-backed data memory: one request at a time,
// read-modify-write for sub-word stores, single-cycle response with error flag.
import mem_req_pkg::*;

module mem_requester #(
    parameter int unsigned MEM_WORDS      = DEFAULT_MEM_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        bus_fault,
    output logic [31:0] mem_in_addr,
    output logic [31:0] mem_in_data,
    output logic        mem_in_valid,
    input  logic        mem_in_ready,
    output logic [31:0] mem_out_addr,
    output logic        mem_out_valid,
    input  logic [31:0] mem_out_data,
    input  logic        mem_out_ready,
    input  logic        mem_addr_error
);

    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        state;
    logic [1:0]    lane_q;
    size_e         size_q;
    logic          signed_q;
    logic [31:0]   wdata_q;
    logic [TW-1:0] tcnt;
    logic          req_err;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)                              req_err = 1'b1;
        if (req_size == SIZE_HALF && req_addr[0])          req_err = 1'b1;
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS)          req_err = 1'b1;
    end

    mem_lane_align u_align (
        .rdata     (mem_out_data),
        .lane      (lane_q),
        .size      (size_q),
        .sgn       (signed_q),
        .wdata     (wdata_q),
        .load_data (load_ext),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_error    <= 1'b0;
            bus_fault     <= 1'b0;
            mem_in_addr   <= '0;
            mem_in_data   <= '0;
            mem_in_valid  <= 1'b0;
            mem_out_addr  <= '0;
            mem_out_valid <= 1'b0;
            lane_q        <= '0;
            size_q        <= SIZE_BYTE;
            signed_q      <= 1'b0;
            wdata_q       <= '0;
            tcnt          <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (mem_addr_error) bus_fault <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        tcnt      <= '0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            bus_fault  <= 1'b1;
                        end else begin
                            lane_q       <= req_addr[1:0];
                            size_q       <= size_e'(req_size);
                            signed_q     <= req_signed;
                            wdata_q      <= req_wdata;
                            mem_in_addr  <= {req_addr[31:2], 2'b00};
                            mem_out_addr <= {req_addr[31:2], 2'b00};
                            if (!req_write) begin
                                state         <= READ;
                                mem_out_valid <= 1'b1;
                            end else if (req_size == SIZE_WORD) begin
                                state        <= WRITE;
                                mem_in_valid <= 1'b1;
                                mem_in_data  <= req_wdata;
                            end else begin
                                state         <= RMW_READ;
                                mem_out_valid <= 1'b1;
                            end
                        end
                    end
                end
                READ, RMW_READ: begin
                    if (mem_out_ready) begin
                        mem_out_valid <= 1'b0;
                        tcnt          <= '0;
                        if (state == READ) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b0;
                            resp_rdata <= load_ext;
                        end else begin
                            // write valid stays low here, giving the one idle cycle between phases
                            state       <= RMW_WRITE;
                            mem_in_data <= merged;
                        end
                    end else if (tcnt == T_LAST) begin
                        mem_out_valid <= 1'b0;
                        state         <= RESP;
                        resp_valid    <= 1'b1;
                        resp_error    <= 1'b1;
                        resp_rdata    <= '0;
                        bus_fault     <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WRITE, RMW_WRITE: begin
                    if (!mem_in_valid) begin
                        mem_in_valid <= 1'b1;
                    end else if (mem_in_ready) begin
                        mem_in_valid <= 1'b0;
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_error   <= 1'b0;
                        resp_rdata   <= '0;
                    end else if (tcnt == T_LAST) begin
                        mem_in_valid <= 1'b0;
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_error   <= 1'b1;
                        resp_rdata   <= '0;
                        bus_fault    <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
